// File: rtl/multi_dataflow_package.sv
// Shared types and sizing for the multi-dataflow engine controller.
// Holds the FSM state encoding and the counter-width rule.
package multi_dataflow_package;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } engine_state_t;

   // One extra bit so a counter can hold the full CNT_LEN value.
   function automatic int unsigned cnt_w(input int unsigned len);
      return $clog2(len) + 1;
   endfunction

   localparam int unsigned CNT_W = cnt_w(1024);

endpackage

// File: rtl/multi_dataflow_out_counter.sv
// One output-stream channel: latched limit, saturating transfer counter,
// sticky overrun flag and a 'reached' indication for the completion check.
module multi_dataflow_out_counter #(
   parameter int unsigned CW = 11
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          clear_i,
   input  logic          load_i,
   input  logic          count_en_i,
   input  logic          hs_i,
   input  logic [CW-1:0] limit_i,
   output logic [CW-1:0] cnt_o,
   output logic          overrun_o,
   output logic          reached_o
);

   logic [CW-1:0] lim_q;
   logic          active;

   // A zero limit masks the channel: it is always reached and never counts.
   assign active    = (lim_q != '0);
   assign reached_o = !active || (cnt_o == lim_q);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lim_q     <= '0;
         cnt_o     <= '0;
         overrun_o <= 1'b0;
      end else if (clear_i) begin
         lim_q     <= '0;
         cnt_o     <= '0;
         overrun_o <= 1'b0;
      end else if (load_i) begin
         lim_q     <= limit_i;
         cnt_o     <= '0;
         overrun_o <= 1'b0;
      end else if (count_en_i && hs_i && active) begin
         if (cnt_o < lim_q) begin
            cnt_o <= cnt_o + 1'b1;
         end else begin
            overrun_o <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/multi_dataflow_engine_ctrl.sv
// Engine controller: launches the kernel, counts output-stream handshakes on
// N_OUT channels and pulses done once every active channel reaches its limit.
module multi_dataflow_engine_ctrl
   import multi_dataflow_package::*;
#(
   parameter int unsigned N_OUT            = 1,
   parameter int unsigned CNT_LEN          = 1024,
   parameter bit          WAIT_KERNEL_DONE = 1'b1
) (
   input  logic                                    clk_i,
   input  logic                                    rst_ni,
   input  logic                                    clear_i,
   input  logic                                    enable_i,
   input  logic                                    start_i,
   input  logic [N_OUT-1:0][cnt_w(CNT_LEN)-1:0]    cnt_limit_i,
   input  logic [N_OUT-1:0]                        out_valid_i,
   input  logic [N_OUT-1:0]                        out_ready_i,
   input  logic                                    kernel_done_i,
   input  logic                                    kernel_idle_i,
   output logic                                    kernel_start_o,
   output logic [N_OUT-1:0][cnt_w(CNT_LEN)-1:0]    cnt_o,
   output logic [N_OUT-1:0]                        overrun_o,
   output logic                                    done_o,
   output logic                                    ready_o,
   output logic                                    busy_o,
   output engine_state_t                           state_o
);

   localparam int unsigned CW = cnt_w(CNT_LEN);

   // Handshake taps are observe-only: a transfer is valid & ready in the same cycle.
   engine_state_t    state_q, state_d;
   logic [N_OUT-1:0] reached;
   logic             all_reached;
   logic             load;
   logic             count_en;
   logic             kdone_q;

   assign ready_o     = (state_q == IDLE) & kernel_idle_i;
   assign load        = ready_o & start_i & enable_i;
   assign count_en    = (state_q == RUN) & enable_i;
   assign all_reached = &reached;
   assign state_o     = state_q;

   for (genvar g = 0; g < N_OUT; g++) begin : g_chan
      multi_dataflow_out_counter #(
         .CW (CW)
      ) u_cnt (
         .clk_i      (clk_i),
         .rst_ni     (rst_ni),
         .clear_i    (clear_i),
         .load_i     (load),
         .count_en_i (count_en),
         .hs_i       (out_valid_i[g] & out_ready_i[g]),
         .limit_i    (cnt_limit_i[g]),
         .cnt_o      (cnt_o[g]),
         .overrun_o  (overrun_o[g]),
         .reached_o  (reached[g])
      );
   end

   // In START the counters are freshly zeroed, so all_reached means every limit is 0.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (load) state_d = START;
         START:   if (enable_i) state_d = all_reached ? DONE : RUN;
         RUN:     if (enable_i && all_reached && (kdone_q || !WAIT_KERNEL_DONE)) state_d = DONE;
         DONE:    if (enable_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q        <= IDLE;
         kdone_q        <= 1'b0;
         kernel_start_o <= 1'b0;
         done_o         <= 1'b0;
         busy_o         <= 1'b0;
      end else if (clear_i) begin
         state_q        <= IDLE;
         kdone_q        <= 1'b0;
         kernel_start_o <= 1'b0;
         done_o         <= 1'b0;
         busy_o         <= 1'b0;
      end else begin
         state_q <= state_d;
         if (load) begin
            kdone_q <= 1'b0;
         end else if (kernel_done_i && (state_q == START || state_q == RUN)) begin
            kdone_q <= 1'b1;
         end
         // Pulses fire on state entry only, so a frozen state does not repeat them.
         kernel_start_o <= (state_d == START) && (state_q != START);
         done_o         <= (state_d == DONE) && (state_q != DONE);
         busy_o         <= (state_d != IDLE);
      end
   end

endmodule
